// File: rtl/bnn_pkg.sv
// bnn_pkg: shared phase codes, layer sizes and layer_three FSM encoding.
// Used by layer_three and its popcount49 helper.
package bnn_pkg;

  localparam logic [2:0] s_LAYER_2 = 3'b011;
  localparam logic [2:0] s_LAYER_3 = 3'b100;

  localparam int FEAT_BITS   = 196;
  localparam int CHUNK_BITS  = 49;
  localparam int NUM_CLASSES = 10;
  localparam int NUM_CHUNKS  = FEAT_BITS / CHUNK_BITS;

  typedef enum logic [1:0] {
    L3_IDLE    = 2'd0,
    L3_ACCUM   = 2'd1,
    L3_COMPARE = 2'd2,
    L3_DONE    = 2'd3
  } l3_fsm_t;

endpackage

// File: rtl/popcount49.sv
// popcount49: combinational 49-bit population count, 6-bit result.
// Used by layer_three to score one feature chunk per cycle.
module popcount49
  import bnn_pkg::*;
(
  input  logic [CHUNK_BITS-1:0] i_bits,
  output logic [5:0]            o_count
);

  // sum of set bits; 49 fits in 6 bits
  always_comb begin
    o_count = '0;
    for (int i = 0; i < CHUNK_BITS; i++)
      o_count = o_count + 6'(i_bits[i]);
  end

endmodule

// File: rtl/layer_three.sv
// layer_three: binary dense layer, XNOR-popcount per class and argmax.
// Optional macro LAYER_THREE_SCORES_EN exposes every class score.
module layer_three
  import bnn_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [2:0]                      state,
  input  logic [FEAT_BITS-1:0]            features,
  input  logic [FEAT_BITS*NUM_CLASSES-1:0] weights,
  output logic [3:0]                      digit,
  output logic [7:0]                      score,
  output logic                            busy,
  output logic                            done
`ifdef LAYER_THREE_SCORES_EN
  ,
  output logic [8*NUM_CLASSES-1:0]        class_scores
`endif
);

  l3_fsm_t r_fsm;
  l3_fsm_t w_fsm_nxt;

  logic [3:0]  r_cls;
  logic [1:0]  r_chunk;
  logic [7:0]  r_acc;
  logic [7:0]  r_best_score;
  logic [3:0]  r_best_cls;
  logic [3:0]  r_digit;
  logic [7:0]  r_score;
  logic        r_done;

  logic        w_go;
  logic        w_last_chunk;
  logic        w_last_cls;
  logic        w_better;
  logic [7:0]  w_fbase;
  logic [10:0] w_wbase;
  logic [CHUNK_BITS-1:0] w_feat;
  logic [CHUNK_BITS-1:0] w_wt;
  logic [CHUNK_BITS-1:0] w_xnor;
  logic [5:0]  w_pc;
  logic [3:0]  w_win_cls;
  logic [7:0]  w_win_score;

  assign w_go         = (state == s_LAYER_3);
  assign w_last_chunk = (r_chunk == 2'(NUM_CHUNKS - 1));
  assign w_last_cls   = (r_cls == 4'(NUM_CLASSES - 1));
  assign w_better     = (r_acc > r_best_score);

  assign w_fbase = 8'(r_chunk) * 8'(CHUNK_BITS);
  assign w_wbase = 11'(r_cls) * 11'(FEAT_BITS)
                 + 11'(w_fbase);

  assign w_feat = features[w_fbase +: CHUNK_BITS];
  assign w_wt   = weights[w_wbase +: CHUNK_BITS];
  assign w_xnor = ~(w_feat ^ w_wt);

  assign w_win_cls   = w_better ? r_cls : r_best_cls;
  assign w_win_score = w_better ? r_acc : r_best_score;

  popcount49 u_pc (
    .i_bits  (w_xnor),
    .o_count (w_pc)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= L3_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // next-state: leaving the layer phase always falls back to IDLE
  always_comb begin
    w_fsm_nxt = r_fsm;
    unique case (r_fsm)
      L3_IDLE:
        if (w_go) w_fsm_nxt = L3_ACCUM;
      L3_ACCUM:
        if (!w_go)             w_fsm_nxt = L3_IDLE;
        else if (w_last_chunk) w_fsm_nxt = L3_COMPARE;
      L3_COMPARE:
        if (!w_go)           w_fsm_nxt = L3_IDLE;
        else if (w_last_cls) w_fsm_nxt = L3_DONE;
        else                 w_fsm_nxt = L3_ACCUM;
      L3_DONE:
        if (!w_go) w_fsm_nxt = L3_IDLE;
      default:
        w_fsm_nxt = L3_IDLE;
    endcase
  end

  // outputs decoded from FSM state
  always_comb begin
    busy = 1'b0;
    unique case (r_fsm)
      L3_ACCUM, L3_COMPARE: busy = 1'b1;
      default:              busy = 1'b0;
    endcase
  end

  // accumulator, running best and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cls        <= '0;
      r_chunk      <= '0;
      r_acc        <= '0;
      r_best_score <= '0;
      r_best_cls   <= '0;
      r_digit      <= '0;
      r_score      <= '0;
      r_done       <= 1'b0;
    end else begin
      unique case (r_fsm)
        L3_IDLE: begin
          if (w_go) begin
            r_cls        <= '0;
            r_chunk      <= '0;
            r_acc        <= '0;
            r_best_score <= '0;
            r_best_cls   <= '0;
          end
        end
        L3_ACCUM: begin
          if (!w_go) begin
            r_acc <= '0;
          end else begin
            r_acc   <= r_acc + 8'(w_pc);
            r_chunk <= r_chunk + 2'd1;
          end
        end
        L3_COMPARE: begin
          if (!w_go) begin
            r_acc <= '0;
          end else begin
            r_best_score <= w_win_score;
            r_best_cls   <= w_win_cls;
            if (w_last_cls) begin
              r_digit <= w_win_cls;
              r_score <= w_win_score;
              r_done  <= 1'b1;
            end else begin
              r_cls   <= r_cls + 4'd1;
              r_chunk <= '0;
              r_acc   <= '0;
            end
          end
        end
        L3_DONE: begin
          if (!w_go) r_done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign digit = r_digit;
  assign score = r_score;
  assign done  = r_done;

`ifdef LAYER_THREE_SCORES_EN
  logic [8*NUM_CLASSES-1:0] r_scores;
  logic [6:0]               w_sidx;

  assign w_sidx = 7'(r_cls) * 7'd8;

  // capture each class total as it is compared
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_scores <= '0;
    else if (r_fsm == L3_COMPARE && w_go)
      r_scores[w_sidx +: 8] <= r_acc;
  end

  assign class_scores = r_scores;
`endif

endmodule

// File: tb/tb_layer_three.sv
// tb_layer_three: table-driven and random checks of layer_three.
// Reference scores are computed directly from the XNOR-popcount rule.
module tb_layer_three;
  import bnn_pkg::*;

  logic          clk;
  logic          rst;
  logic [2:0]    state;
  logic [195:0]  features;
  logic [1959:0] weights;
  logic [3:0]    digit;
  logic [7:0]    score;
  logic          busy;
  logic          done;
`ifdef LAYER_THREE_SCORES_EN
  logic [79:0]   class_scores;
`endif

  int n_vec = 0;
  int n_bad = 0;

  layer_three dut (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .features (features),
    .weights  (weights),
    .digit    (digit),
    .score    (score),
    .busy     (busy),
    .done     (done)
`ifdef LAYER_THREE_SCORES_EN
    ,
    .class_scores (class_scores)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [195:0]  f;
    logic [1959:0] w;
    int            d;
    int            s;
  } vec_t;

  vec_t tab[8];

  task automatic chk(input string n, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic int match(input logic [195:0] f,
                               input logic [1959:0] w,
                               input int c);
    int n = 0;
    for (int i = 0; i < 196; i++)
      if (f[i] == w[c*196+i]) n++;
    return n;
  endfunction

  function automatic logic [195:0] ones(input int n);
    logic [195:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic void ref_best(input logic [195:0] f,
                                   input logic [1959:0] w,
                                   output int d, output int s);
    d = 0;
    s = -1;
    for (int c = 0; c < 10; c++)
      if (match(f, w, c) > s) begin
        s = match(f, w, c);
        d = c;
      end
  endfunction

  // apply one vector, run to done, check timing, result and exit
  task automatic run_check(input vec_t v, input string tag);
    int edges = 0;
    int bc = 0;
    bit got = 0;
    features = v.f;
    weights  = v.w;
    state    = s_LAYER_3;
    while (edges < 100 && !got) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy) bc++;
      if (done) got = 1;
    end
    chk({tag, "_latency"}, edges, 51);
    chk({tag, "_busy_cycles"}, bc, 50);
    chk({tag, "_digit"}, int'(digit), v.d);
    chk({tag, "_score"}, int'(score), v.s);
`ifdef LAYER_THREE_SCORES_EN
    for (int k = 0; k < 10; k++)
      chk({tag, "_class_score"}, int'(class_scores[k*8 +: 8]),
          match(v.f, v.w, k));
`endif
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_hold_done"}, int'(done), 1);
    state = s_LAYER_2;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_exit_done"}, int'(done), 0);
    chk({tag, "_exit_digit"}, int'(digit), v.d);
    chk({tag, "_exit_score"}, int'(score), v.s);
  endtask

  initial begin
    // one-hot winner: class 7 is the only full match
    tab[0].f = '0;
    tab[0].w = '1;
    tab[0].w[7*196 +: 196] = '0;
    tab[0].d = 7;
    tab[0].s = 196;
    // tie between 3 and 5 resolves to the lower index
    tab[1].f = '1;
    for (int c = 0; c < 10; c++)
      tab[1].w[c*196 +: 196] = ones((c == 3 || c == 5) ? 150 : 100);
    tab[1].d = 3;
    tab[1].s = 150;
    // all rows identical
    tab[2].f = '1;
    for (int c = 0; c < 10; c++)
      tab[2].w[c*196 +: 196] = ones(98);
    tab[2].d = 0;
    tab[2].s = 98;
    // random rows scored by the reference
    for (int t = 3; t < 8; t++) begin
      for (int i = 0; i < 196; i++)
        tab[t].f[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 1960; i++)
        tab[t].w[i] = 1'($urandom_range(0, 1));
      ref_best(tab[t].f, tab[t].w, tab[t].d, tab[t].s);
    end

    rst      = 1'b1;
    state    = 3'b000;
    features = '0;
    weights  = '0;
    repeat (3) @(negedge clk);
    chk("reset_digit", int'(digit), 0);
    chk("reset_score", int'(score), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    run_check(tab[0], "onehot");

    // asynchronous reset mid-accumulation, then a clean rerun
    features = tab[1].f;
    weights  = tab[1].w;
    state    = s_LAYER_3;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_digit", int'(digit), 0);
    chk("arst_score", int'(score), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    run_check(tab[1], "after_rst");

    // abort at edge 20 keeps previous result, rerun completes
    features = tab[2].f;
    weights  = tab[2].w;
    state    = s_LAYER_3;
    repeat (19) @(posedge clk);
    @(negedge clk);
    state = s_LAYER_2;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_digit", int'(digit), 3);
    chk("abort_score", int'(score), 150);
    @(negedge clk);
    run_check(tab[2], "after_abort");

    for (int t = 0; t < 8; t++)
      run_check(tab[t], $sformatf("vec%0d", t));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/layer_three.md
LAYER_THREE -- requirements
Module: layer_three

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port state, input, 3, the global network phase; the block runs only while state==s_LAYER_3 (3'b100).
REQ-004 SHALL have port features, input, 196, the binary feature map, index wn*49 + row*7 + col (4 filters x 7x7).
REQ-005 SHALL have port weights, input, 1960, the dense binary weights, index cls*196 + i for feature bit i.
REQ-006 SHALL have port digit, output, 4, the winning class index 0..9.
REQ-007 SHALL have port score, output, 8, the winning class XNOR-popcount, 0..196.
REQ-008 SHALL have port busy, output, 1, high in ACCUM and COMPARE.
REQ-009 SHALL have port done, output, 1, high once classification of the current run is complete.

Function
REQ-010 SHALL implement FSM states IDLE, ACCUM, COMPARE and DONE.
REQ-011 In IDLE with state==s_LAYER_3, SHALL go to ACCUM next edge and clear cls, chunk, acc, best_score and best_cls to 0.
REQ-012 Each ACCUM cycle SHALL do acc <= acc + popcount(~(features[chunk*49 +: 49] ^ weights[cls*196 + chunk*49 +: 49])), then chunk <= chunk+1.
REQ-013 SHALL move from ACCUM to COMPARE after the chunk==3 update, so there are 4 ACCUM cycles per class.
REQ-014 In COMPARE, if acc > best_score (strict), SHALL set best_score<=acc and best_cls<=cls; ties keep the lower class index.
REQ-015 From COMPARE, if cls<9, SHALL do cls<=cls+1, chunk<=0, acc<=0 and return to ACCUM; if cls==9, SHALL go to DONE.
REQ-016 On the cls==9 COMPARE edge, SHALL load digit<=final best_cls, score<=final best_score and done<=1 in the same edge.
REQ-017 Latency SHALL be: done high after the 51st rising edge, counting the IDLE edge that first samples state==s_LAYER_3 (1 + 10x5).
REQ-018 SHALL hold DONE, with done=1, while state==s_LAYER_3.
REQ-019 When state!=s_LAYER_3 in DONE, SHALL go to IDLE and clear done; digit and score SHALL be retained.
REQ-020 If state leaves s_LAYER_3 during ACCUM or COMPARE, SHALL abort to IDLE next edge, clear acc, keep done=0, and leave digit and score at their last completed values.
REQ-021 acc and score SHALL be 8-bit unsigned with no overflow (max 196); the per-chunk popcount SHALL be 6 bits.
REQ-022 features and weights SHALL be assumed stable from entry into ACCUM until done.

Reset
REQ-023 rst high SHALL asynchronously force IDLE with digit=0, score=0, done=0, busy=0, acc=0, cls=0, chunk=0, best_score=0, best_cls=0.
REQ-024 Reset asserted mid-run SHALL discard the run; after release, a new run SHALL start only through REQ-011.

Configuration
REQ-025 The macro LAYER_THREE_SCORES_EN SHALL control an extra score output.
- Defined: adds output class_scores [79:0], with class k score at bits k*8 +: 8; written with acc at each COMPARE; reset to 0; not cleared by abort.
- Undefined: the port and its registers are absent; all other behaviour is identical.

Structure
REQ-026 Shared package bnn_pkg SHALL hold:
- phase codes s_LAYER_2=3'b011 and s_LAYER_3=3'b100;
- FEAT_BITS=196, CHUNK_BITS=49, NUM_CLASSES=10;
- the layer_three FSM state encoding.
REQ-027 SHALL instantiate one sub-module popcount49, a combinational 49-bit to 6-bit population count; the FSM and accumulator SHALL stay in layer_three.

Verification
REQ-028 Reset check: assert rst mid-ACCUM -> digit=0, score=0, done=0 and busy=0 immediately (asynchronous); release with state held at s_LAYER_3 -> done after 51 edges.
REQ-029 One-hot winner: features all 0; class 7 weights all 0, others all 1 -> digit=7, score=196, done after exactly 51 edges, busy high for 50 cycles.
REQ-030 Tie-break: features all 1; classes 3 and 5 weights have 150 ones each, others 100 -> digit=3, score=150.
REQ-031 Equal classes: all weight rows identical with 98 matches -> digit=0, score=98.
REQ-032 Abort: state falls to 3'b011 at edge 20 -> IDLE, done=0, previous digit retained; re-enter s_LAYER_3 -> full 51-edge run with the correct result.
REQ-033 With LAYER_THREE_SCORES_EN: random features and weights -> every class_scores byte equals a reference XNOR-popcount, and digit is the argmax with lowest-index ties.
